m65_scancode_sequencer: RTL

Converts the MEGA65 M2M keyboard scan stream (`key_num` sweeping 0..79, `key_status_n` low = pressed) into PS/2 set-2 style key events (`scan_received` pulse, `scancode`, `extended`, `released`). It sits between the M2M keyboard interface and the KBSTATUS/SCANCODE registers, special-function decoder, pressed-status tracker and keymap translator. It detects per-key state changes and queues them in a FIFO. It then issues them one at a time, paced by a minimum gap and an optional host acknowledge.

---
 rtl/m65_scancode_sequencer_if.sv | 23 ++
 rtl/m65_scancode_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/m65_scancode_sequencer_if.sv
// rtl/m65_scancode_sequencer_if.sv - key scan input and PS/2 key event output bundle
// The scanner/host side drives the master modport; the sequencer uses the slave modport.
interface m65_scancode_sequencer_if;
  logic [6:0] key_num;
  logic       key_status_n;
  logic       host_ack;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic [6:0] keys_down;
  logic       overflow;

  modport master (
    output key_num, key_status_n, host_ack,
    input  scan_received, scancode, extended, released, keys_down, overflow
  );

  modport slave (
    input  key_num, key_status_n, host_ack,
    output scan_received, scancode, extended, released, keys_down, overflow
  );
endinterface

// File: rtl/m65_scancode_sequencer.sv
// rtl/m65_scancode_sequencer.sv - M2M key scan to PS/2 set-2 key event sequencer
// Define SCANSEQ_DEBOUNCE_EN to accept a change only after two matching sightings.
module m65_scancode_sequencer #(
  parameter int GAP_CYCLES      = 16,
  parameter int WAIT_ACK        = 0,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  m65_scancode_sequencer_if.slave        io_kb
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]              GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_POP, S_PULSE, S_WAITACK, S_GAP} state_t;

  // {ext, code}; a zero entry marks a key handled elsewhere (never queued)
  function automatic logic [8:0] rom_lookup(input logic [6:0] k);
    logic [8:0] v;
    v = 9'h000;
    case (k)
      7'd0:  v = 9'h066; 7'd1:  v = 9'h05A; 7'd2:  v = 9'h174; 7'd3:  v = 9'h083;
      7'd4:  v = 9'h005; 7'd5:  v = 9'h004; 7'd6:  v = 9'h003; 7'd7:  v = 9'h172;
      7'd8:  v = 9'h026; 7'd9:  v = 9'h01D; 7'd10: v = 9'h01C; 7'd11: v = 9'h025;
      7'd12: v = 9'h01A; 7'd13: v = 9'h01B; 7'd14: v = 9'h024; 7'd15: v = 9'h012;
      7'd16: v = 9'h02E; 7'd17: v = 9'h02D; 7'd18: v = 9'h023; 7'd19: v = 9'h036;
      7'd20: v = 9'h021; 7'd21: v = 9'h02B; 7'd22: v = 9'h02C; 7'd23: v = 9'h022;
      7'd24: v = 9'h03D; 7'd25: v = 9'h035; 7'd26: v = 9'h034; 7'd27: v = 9'h03E;
      7'd28: v = 9'h032; 7'd29: v = 9'h033; 7'd30: v = 9'h03C; 7'd31: v = 9'h02A;
      7'd32: v = 9'h046; 7'd33: v = 9'h043; 7'd34: v = 9'h03B; 7'd35: v = 9'h045;
      7'd36: v = 9'h03A; 7'd37: v = 9'h042; 7'd38: v = 9'h044; 7'd39: v = 9'h031;
      7'd40: v = 9'h055; 7'd41: v = 9'h04D; 7'd42: v = 9'h04B; 7'd43: v = 9'h04E;
      7'd44: v = 9'h049; 7'd45: v = 9'h04C; 7'd46: v = 9'h054; 7'd47: v = 9'h041;
      7'd48: v = 9'h05D; 7'd49: v = 9'h05B; 7'd50: v = 9'h052; 7'd51: v = 9'h16C;
      7'd52: v = 9'h059; 7'd53: v = 9'h00E; 7'd54: v = 9'h17D; 7'd55: v = 9'h04A;
      7'd56: v = 9'h016; 7'd57: v = 9'h171; 7'd58: v = 9'h014; 7'd59: v = 9'h01E;
      7'd60: v = 9'h029; 7'd61: v = 9'h11F; 7'd62: v = 9'h015; 7'd63: v = 9'h076;
      7'd64: v = 9'h07E; 7'd65: v = 9'h00D; 7'd66: v = 9'h011; 7'd67: v = 9'h00A;
      7'd68: v = 9'h001; 7'd69: v = 9'h078; 7'd70: v = 9'h007; 7'd71: v = 9'h008;
      7'd72: v = 9'h058; 7'd73: v = 9'h175; 7'd74: v = 9'h16B;
      default: v = 9'h000;
    endcase
    return v;
  endfunction

  logic [6:0]  r_last_idx, r_s_idx, r_keys_down;
  logic        r_s_vld, r_s_p, r_overflow;
  logic [79:0] r_down;
  logic [7:0]  r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic [GW-1:0] r_gap_cnt;
  logic [7:0]  r_scancode;
  logic        r_extended, r_released;
  state_t      r_state, w_next;
  logic        w_cur, w_diff, w_change, w_rom_nz, w_full, w_empty;
  logic        w_accept, w_push, w_pop, w_pulse;
  logic [8:0]  w_rom_s, w_rom_h;
  logic [7:0]  w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_idx <= 7'h7F;
      r_s_vld    <= 1'b0;
      r_s_idx    <= 7'd0;
      r_s_p      <= 1'b0;
    end else begin
      r_last_idx <= io_kb.key_num;
      r_s_vld    <= (io_kb.key_num != r_last_idx) && (io_kb.key_num < 7'd80);
      r_s_idx    <= io_kb.key_num;
      r_s_p      <= ~io_kb.key_status_n;
    end
  end

  assign w_cur    = r_down[r_s_idx];
  assign w_diff   = r_s_vld && (r_s_p != w_cur);
  assign w_rom_s  = rom_lookup(r_s_idx);
  assign w_rom_nz = |w_rom_s;
  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);

`ifdef SCANSEQ_DEBOUNCE_EN
  // cand[i] == down[i] means no pending candidate for key i
  logic [79:0] r_cand;
  assign w_change = w_diff && (r_cand[r_s_idx] == r_s_p);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cand <= '0;
    else if (r_s_vld)
      r_cand[r_s_idx] <= w_diff ? r_s_p : w_cur;
  end
`else
  assign w_change = w_diff;
`endif

  assign w_accept = w_change && (!w_rom_nz || !w_full);
  assign w_push   = w_accept && w_rom_nz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_down      <= '0;
      r_keys_down <= 7'd0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_down[r_s_idx] <= r_s_p;
        if (r_s_p && r_keys_down != 7'd80)
          r_keys_down <= r_keys_down + 7'd1;
        else if (!r_s_p && r_keys_down != 7'd0)
          r_keys_down <= r_keys_down - 7'd1;
      end
      if (w_change && w_rom_nz && w_full)
        r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {~r_s_p, r_s_idx};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign w_head  = r_mem[r_rd_ptr];
  assign w_rom_h = rom_lookup(w_head[6:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_scancode <= 8'h00;
      r_extended <= 1'b0;
      r_released <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (w_pop) begin
        r_scancode <= w_rom_h[7:0];
        r_extended <= w_rom_h[8];
        r_released <= w_head[7];
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_pop   = 1'b0;
    w_pulse = 1'b0;
    case (r_state)
      S_IDLE:    if (!w_empty) w_next = S_POP;
      S_POP:     begin w_pop = 1'b1; w_next = S_PULSE; end
      S_PULSE:   begin w_pulse = 1'b1; w_next = (WAIT_ACK != 0) ? S_WAITACK : S_GAP; end
      S_WAITACK: if (io_kb.host_ack) w_next = S_GAP;
      S_GAP:     if (r_gap_cnt == GAP_LAST) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  assign io_kb.scan_received = w_pulse;
  assign io_kb.scancode      = r_scancode;
  assign io_kb.extended      = r_extended;
  assign io_kb.released      = r_released;
  assign io_kb.keys_down     = r_keys_down;
  assign io_kb.overflow      = r_overflow;
endmodule
